// File: rtl/risky_pkg.sv
// Shared fetch-side definitions: datapath width, instruction stride,
// default vectors and the pc generator state encoding.
package risky_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] INSTR_STRIDE = 32'd4;
   localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
   localparam logic [XLEN-1:0] TRAP_VECTOR_DEF = 32'h0000_0100;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } pcgen_state_t;

   // Instructions are word aligned; any low-bit set is an illegal target.
   function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/pc_gen_redirect_buf.sv
// One-entry pending redirect buffer. The output mux forwards a same-cycle
// load so the youngest redirect always wins.
module redirect_buf
   import risky_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load_i,
   input  logic            clear_i,
   input  logic [XLEN-1:0] target_i,
   output logic            valid_o,
   output logic [XLEN-1:0] target_o
);

   logic            valid_q, valid_d;
   logic [XLEN-1:0] target_q, target_d;

   always_comb begin
      valid_d  = valid_q;
      target_d = target_q;
      if (clear_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d  = 1'b1;
         target_d = target_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Target storage is meaningless while valid_q is low, so it is not reset.
   always_ff @(posedge clk) begin
      target_q <= target_d;
   end

   assign valid_o  = valid_q | load_i;
   assign target_o = load_i ? target_i : target_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch pc producer: boot hold-off, sequential stepping, stall hold,
// buffered/immediate redirects, trap and misaligned-target diversion.
module pc_gen
   import risky_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
   parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEF,
   parameter int          BOOT_CYCLES  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic        trap_valid,
   output logic [31:0] pc,
   output logic        pc_valid,
   output logic        flush_IF,
   output logic        misalign_err
);

   pcgen_state_t    state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            pc_valid_q, pc_valid_d;
   logic            flush_q, flush_d;
   logic            misalign_q, misalign_d;

   logic            buf_load, buf_clear, buf_valid;
   logic [XLEN-1:0] buf_target;
   logic            apply_en;
   logic [XLEN-1:0] apply_tgt;

   redirect_buf u_redirect_buf (
      .clk      (clk),
      .rst      (rst),
      .load_i   (buf_load),
      .clear_i  (buf_clear),
      .target_i (redirect_target),
      .valid_o  (buf_valid),
      .target_o (buf_target)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pc_d       = pc_q;
      pc_valid_d = pc_valid_q;
      flush_d    = 1'b0;
      misalign_d = 1'b0;
      buf_load   = 1'b0;
      buf_clear  = 1'b0;
      apply_en   = 1'b0;
      apply_tgt  = redirect_target;

      unique case (state_q)
         BOOT: begin
            pc_d = RESET_VECTOR;
            if (cnt_q <= 4'd1) begin
               cnt_d      = 4'd0;
               state_d    = RUN;
               pc_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         RUN: begin
            if (trap_valid) begin
               pc_d      = TRAP_VECTOR;
               flush_d   = 1'b1;
               buf_clear = 1'b1;
            end else if (redirect_valid && !stall) begin
               apply_en  = 1'b1;
               apply_tgt = redirect_target;
            end else if (stall) begin
               buf_load = redirect_valid;
               state_d  = HOLD;
            end else begin
               pc_d = pc_q + INSTR_STRIDE;
            end
         end

         HOLD: begin
            buf_load = redirect_valid;
            if (trap_valid) begin
               pc_d      = TRAP_VECTOR;
               flush_d   = 1'b1;
               buf_clear = 1'b1;
               state_d   = RUN;
            end else if (!stall) begin
               buf_clear = 1'b1;
               state_d   = RUN;
               if (buf_valid) begin
                  apply_en  = 1'b1;
                  apply_tgt = buf_target;
               end else begin
                  pc_d = pc_q + INSTR_STRIDE;
               end
            end
         end

         default: begin
            state_d = BOOT;
         end
      endcase

      // Alignment is judged at the moment a target becomes the pc.
      if (apply_en) begin
         flush_d = 1'b1;
         if (is_misaligned(apply_tgt)) begin
            pc_d       = TRAP_VECTOR;
            misalign_d = 1'b1;
         end else begin
            pc_d = apply_tgt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= BOOT;
         cnt_q      <= 4'(BOOT_CYCLES);
         pc_q       <= RESET_VECTOR;
         pc_valid_q <= 1'b0;
         flush_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pc_q       <= pc_d;
         pc_valid_q <= pc_valid_d;
         flush_q    <= flush_d;
         misalign_q <= misalign_d;
      end
   end

   assign pc           = pc_q;
   assign pc_valid     = pc_valid_q;
   assign flush_IF     = flush_q;
   assign misalign_err = misalign_q;

endmodule
